up_counter_ctrl: RTL and testbench
==================================

Name: up_counter_ctrl

Overview:
- Loadable, programmable-limit up counter with run control. It is the count-up counterpart to the team's loadable down counter.
- Counts from a loaded start value up to a programmable terminal value, then either stops (one-shot) or reloads and continues (auto-reload).
- Used as an event/interval timer in the FlipFlops-and-counter block set; tc feeds downstream counters for cascading.

Parameters:
- W, 4, counter/data width in bits.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous, active-high reset.
- d  input  W  load value; also captured as the reload value.
- load  input  1  load q from d this cycle.
- start  input  1  begin/restart counting.
- stop  input  1  abort counting; q holds.
- en  input  1  count enable (count qualifier while running).
- auto_reload  input  1  1 = reload and continue at limit; 0 = one-shot.
- limit  input  W  terminal count value, sampled every cycle.
- q  output  W  current count (registered).
- tc  output  1  one-cycle terminal-count pulse (registered).
- busy  output  1  high while in RUN.
- done  output  1  high while in DONE (sticky until start/load/rst).

Behaviour:
- All outputs are registered. Reset is sampled on the clk rising edge only.
- rst=1 result: q=0, tc=0, busy=0, done=0, rld=0, state=IDLE.
- rld is an internal W-bit reload register. It is written with d on every accepted load.
- Priority per cycle: rst > load > stop > start > count.
- States: IDLE, RUN, DONE. busy = (state==RUN), done = (state==DONE), both registered with state.
- tc defaults to 0 every cycle unless set by a terminal event below.
- IDLE:
  - load: q<=d, rld<=d, stay IDLE.
  - start: next state RUN. No count in the start cycle; the first increment occurs on the next enabled cycle.
  - en is ignored.
- RUN, en=0: q holds.
- RUN, en=1, q!=limit: q<=q+1 modulo 2^W. Wrap from all-ones to 0 is silent (no tc).
- RUN, en=1, q==limit:
  - tc<=1 in both modes.
  - auto_reload=1: q<=rld, stay RUN.
  - auto_reload=0: q holds at limit, next state DONE.
- RUN, load: q<=d, rld<=d, state stays RUN, no count and no tc that cycle.
- RUN, stop: next state IDLE, q holds, no tc.
- RUN, start: ignored, counting continues.
- DONE:
  - q holds.
  - start: q<=rld, next state RUN.
  - load: q<=d, rld<=d, next state IDLE.
  - stop: next state IDLE.
- limit changing mid-run takes effect on the next comparison.
- Start with limit<q: the count wraps through 0 before reaching limit.
- Latency:
  - q changes one clk after the qualifying edge.
  - tc is asserted in the same clock in which q leaves (or stops at) limit.
  - busy rises one clk after start is accepted.
- Reset mid-RUN: next cycle is the reset state; any pending tc is dropped.

Decomposition:
- Package counter_pkg holds the state encoding constants ST_IDLE=2'd0, ST_RUN=2'd1, ST_DONE=2'd2.
- The down counter can share counter_pkg later.
- No sub-module: a single always block for the state/q/rld registers plus a comparator.

Test Plan:
1. Reset then idle: rst high for 2 clk, start=0 -> q=0, tc=0, busy=0, done=0; load with d=4'h3 -> q=3 next clk, still IDLE.
2. One-shot: load d=2, limit=5, auto_reload=0, start, en=1 -> q goes 2,3,4,5; tc=1 for exactly one clk as q stays at 5; done=1, busy=0; q holds at 5 for 10 further clk.
3. Auto-reload: d=4'hC, limit=4'hE, auto_reload=1, en=1 -> q: C,D,E,C,D,E...; tc pulses once every 3 clk; busy stays 1.
4. Enable gating / wrap: d=4'hE, limit=4'h1, en toggled 1,0,1,1,1 -> q: F,F,0,1, then tc; no tc at the F->0 wrap.
5. Priority: in RUN assert load (d=7) and stop simultaneously -> q=7 and state stays RUN; next clk stop alone -> IDLE with q held; rst together with load -> q=0.
6. Restart from DONE: after scenario 2, pulse start -> q=2 (rld), busy=1, done=0, counting resumes to 5; mid-run rst -> q=0, all flags 0 next clk.

Source files
------------

// File: rtl/up_counter_ctrl_pkg.sv
// Shared definitions for the counter block set (up counter now, down counter
// later). Holds the controller state encoding.
//   state_t : IDLE / RUN / DONE, 2-bit encoded.
package counter_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    // Terminal-count compare used by the counter datapath.
    function automatic logic at_terminal(input logic [15:0] cnt, input logic [15:0] lim);
        return cnt == lim;
    endfunction

endpackage

// File: rtl/up_counter_ctrl_if.sv
// Control/status bundle for up_counter_ctrl.
//   d           load / reload value (W bits)
//   load        load q and reload register from d
//   start       begin or restart counting
//   stop        abort counting, q holds
//   en          count enable while running
//   auto_reload 1 = reload from rld at limit, 0 = one-shot
//   limit       terminal count value (W bits)
//   q           current count (W bits, registered)
//   tc          one-cycle terminal-count pulse
//   busy        high while running
//   done        high while finished (one-shot)
// master: the controlling agent; slave: the counter itself.
interface up_counter_ctrl_if #(
    parameter int W = 4
);
    logic [W-1:0] d;
    logic         load;
    logic         start;
    logic         stop;
    logic         en;
    logic         auto_reload;
    logic [W-1:0] limit;
    logic [W-1:0] q;
    logic         tc;
    logic         busy;
    logic         done;

    modport master (
        output d, load, start, stop, en, auto_reload, limit,
        input  q, tc, busy, done
    );

    modport slave (
        input  d, load, start, stop, en, auto_reload, limit,
        output q, tc, busy, done
    );

endinterface

// File: rtl/up_counter_ctrl.sv
// Loadable, programmable-limit up counter with run control.
// Counts from a loaded start value up to limit, then stops (one-shot) or
// reloads from the captured load value and keeps going (auto-reload).
// Ports:
//   clk  rising-edge clock
//   rst  synchronous active-high reset
//   bus  up_counter_ctrl_if.slave (d, load, start, stop, en, auto_reload,
//        limit in; q, tc, busy, done out, all outputs registered)
// Per-cycle priority: rst > load > stop > start > count.
module up_counter_ctrl
    import counter_pkg::*;
#(
    parameter int W = 4
) (
    input logic              clk,
    input logic              rst,
    up_counter_ctrl_if.slave bus
);

    state_t       state, state_n;
    logic [W-1:0] q_r, q_n;
    logic [W-1:0] rld_r, rld_n;
    logic         tc_r, tc_n;
    logic         busy_r, done_r;
    logic         at_limit;

    // Compare uses the live limit, so a mid-run change applies immediately.
    assign at_limit = at_terminal(16'(q_r), 16'(bus.limit));

    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= ST_IDLE;
            q_r    <= '0;
            rld_r  <= '0;
            tc_r   <= 1'b0;
            busy_r <= 1'b0;
            done_r <= 1'b0;
        end else begin
            state  <= state_n;
            q_r    <= q_n;
            rld_r  <= rld_n;
            tc_r   <= tc_n;
            // Flags follow the next state so they line up with state itself.
            busy_r <= (state_n == ST_RUN);
            done_r <= (state_n == ST_DONE);
        end
    end

    always_comb begin
        state_n = state;
        q_n     = q_r;
        rld_n   = rld_r;
        tc_n    = 1'b0;

        unique case (state)
            ST_IDLE: begin
                if (bus.load) begin
                    q_n   = bus.d;
                    rld_n = bus.d;
                end else if (bus.stop) begin
                    state_n = ST_IDLE;
                end else if (bus.start) begin
                    // No increment in the start cycle itself.
                    state_n = ST_RUN;
                end
            end

            ST_RUN: begin
                if (bus.load) begin
                    q_n   = bus.d;
                    rld_n = bus.d;
                end else if (bus.stop) begin
                    state_n = ST_IDLE;
                end else if (bus.en) begin
                    // start is ignored here; counting proceeds.
                    if (at_limit) begin
                        tc_n = 1'b1;
                        if (bus.auto_reload) begin
                            q_n = rld_r;
                        end else begin
                            state_n = ST_DONE;
                        end
                    end else begin
                        // Wrap from all-ones to zero is silent.
                        q_n = q_r + 1'b1;
                    end
                end
            end

            ST_DONE: begin
                if (bus.load) begin
                    q_n     = bus.d;
                    rld_n   = bus.d;
                    state_n = ST_IDLE;
                end else if (bus.stop) begin
                    state_n = ST_IDLE;
                end else if (bus.start) begin
                    q_n     = rld_r;
                    state_n = ST_RUN;
                end
            end

            default: begin
                state_n = ST_IDLE;
            end
        endcase
    end

    assign bus.q    = q_r;
    assign bus.tc   = tc_r;
    assign bus.busy = busy_r;
    assign bus.done = done_r;

endmodule

// File: tb/tb_up_counter_ctrl.sv
// Self-checking bench for up_counter_ctrl: directed scenarios checked against
// literal expectations, then randomized traffic checked against a
// behavioural model of the counter's rules.
module tb_up_counter_ctrl;

    localparam int W = 4;

    logic clk;
    logic rst;
    int   checks;
    int   errors;

    // Behavioural model: count value, reload value, running / finished flags.
    int m_q, m_rld;
    bit m_tc, m_run, m_done;

    up_counter_ctrl_if #(.W(W)) bus();

    up_counter_ctrl #(.W(W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Apply the counter's rules to the inputs presented this cycle.
    task automatic model_step();
        int modw;
        modw = 1 << W;
        m_tc = 1'b0;
        if (rst) begin
            m_q = 0; m_rld = 0; m_run = 1'b0; m_done = 1'b0;
        end else if (bus.load) begin
            m_q = int'(bus.d); m_rld = int'(bus.d);
            m_done = 1'b0;
        end else if (bus.stop) begin
            m_run = 1'b0; m_done = 1'b0;
        end else if (bus.start && !m_run) begin
            if (m_done) m_q = m_rld;
            m_done = 1'b0;
            m_run  = 1'b1;
        end else if (m_run && bus.en) begin
            if (m_q == int'(bus.limit)) begin
                m_tc = 1'b1;
                if (bus.auto_reload) m_q = m_rld;
                else begin
                    m_run = 1'b0; m_done = 1'b1;
                end
            end else begin
                m_q = (m_q + 1) % modw;
            end
        end
    endtask

    // One clock: model follows the same inputs, outputs sampled 1 after edge.
    task automatic tick();
        model_step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick();
        tick();
        checks++;
        if (bus.q !== 4'h0 || bus.tc !== 1'b0 || bus.busy !== 1'b0 || bus.done !== 1'b0) begin
            errors++;
            $display("FAIL reset: got q=%0h tc=%0b busy=%0b done=%0b expected q=0 tc=0 busy=0 done=0",
                     bus.q, bus.tc, bus.busy, bus.done);
        end
        rst = 1'b0;
    endtask

    task automatic test_idle_load();
        bus.d = 4'h3; bus.load = 1'b1;
        tick();
        bus.load = 1'b0;
        checks++;
        if (bus.q !== 4'h3 || bus.busy !== 1'b0 || bus.done !== 1'b0) begin
            errors++;
            $display("FAIL idle_load: got q=%0h busy=%0b done=%0b expected q=3 busy=0 done=0",
                     bus.q, bus.busy, bus.done);
        end
        // en alone must not move the count in IDLE
        bus.en = 1'b1;
        tick();
        checks++;
        if (bus.q !== 4'h3) begin
            errors++;
            $display("FAIL idle_en_ignored: got q=%0h expected 3", bus.q);
        end
        bus.en = 1'b0;
    endtask

    task automatic test_one_shot();
        logic [3:0] expq;
        bus.d = 4'h2; bus.limit = 4'h5; bus.auto_reload = 1'b0; bus.load = 1'b1;
        tick();
        bus.load = 1'b0; bus.start = 1'b1; bus.en = 1'b1;
        tick();
        bus.start = 1'b0;
        checks++;
        if (bus.q !== 4'h2 || bus.busy !== 1'b1) begin
            errors++;
            $display("FAIL one_shot_start: got q=%0h busy=%0b expected q=2 busy=1", bus.q, bus.busy);
        end
        for (int unsigned i = 0; i < 3; i++) begin
            tick();
            expq = 4'(3 + i);
            checks++;
            if (bus.q !== expq || bus.tc !== 1'b0) begin
                errors++;
                $display("FAIL one_shot_count: got q=%0h tc=%0b expected q=%0h tc=0", bus.q, bus.tc, expq);
            end
        end
        tick();
        checks++;
        if (bus.q !== 4'h5 || bus.tc !== 1'b1 || bus.done !== 1'b1 || bus.busy !== 1'b0) begin
            errors++;
            $display("FAIL one_shot_tc: got q=%0h tc=%0b done=%0b busy=%0b expected q=5 tc=1 done=1 busy=0",
                     bus.q, bus.tc, bus.done, bus.busy);
        end
        for (int unsigned i = 0; i < 10; i++) begin
            tick();
            checks++;
            if (bus.q !== 4'h5 || bus.tc !== 1'b0 || bus.done !== 1'b1) begin
                errors++;
                $display("FAIL one_shot_hold: got q=%0h tc=%0b done=%0b expected q=5 tc=0 done=1",
                         bus.q, bus.tc, bus.done);
            end
        end
    endtask

    task automatic test_restart_done();
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        checks++;
        if (bus.q !== 4'h2 || bus.busy !== 1'b1 || bus.done !== 1'b0) begin
            errors++;
            $display("FAIL restart: got q=%0h busy=%0b done=%0b expected q=2 busy=1 done=0",
                     bus.q, bus.busy, bus.done);
        end
        tick(); tick(); tick();
        checks++;
        if (bus.q !== 4'h5 || bus.busy !== 1'b1 || bus.tc !== 1'b0) begin
            errors++;
            $display("FAIL restart_count: got q=%0h busy=%0b tc=%0b expected q=5 busy=1 tc=0",
                     bus.q, bus.busy, bus.tc);
        end
        // q is at limit with en high: reset must drop the pending tc
        rst = 1'b1;
        tick();
        rst = 1'b0;
        checks++;
        if (bus.q !== 4'h0 || bus.tc !== 1'b0 || bus.busy !== 1'b0 || bus.done !== 1'b0) begin
            errors++;
            $display("FAIL midrun_reset: got q=%0h tc=%0b busy=%0b done=%0b expected all 0",
                     bus.q, bus.tc, bus.busy, bus.done);
        end
    endtask

    task automatic test_auto_reload();
        logic [3:0] seq [9];
        int         tcs;
        seq = '{4'hD, 4'hE, 4'hC, 4'hD, 4'hE, 4'hC, 4'hD, 4'hE, 4'hC};
        tcs = 0;
        bus.d = 4'hC; bus.limit = 4'hE; bus.auto_reload = 1'b1; bus.en = 1'b1; bus.load = 1'b1;
        tick();
        bus.load = 1'b0; bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        for (int unsigned i = 0; i < 9; i++) begin
            tick();
            if (bus.tc === 1'b1) tcs++;
            checks++;
            if (bus.q !== seq[i] || bus.busy !== 1'b1 || bus.tc !== (seq[i] == 4'hC)) begin
                errors++;
                $display("FAIL auto_reload step %0d: got q=%0h tc=%0b busy=%0b expected q=%0h tc=%0b busy=1",
                         i, bus.q, bus.tc, bus.busy, seq[i], (seq[i] == 4'hC));
            end
        end
        checks++;
        if (tcs != 3) begin
            errors++;
            $display("FAIL auto_reload_tc_count: got %0d expected 3", tcs);
        end
    endtask

    task automatic test_wrap_gating();
        logic       ens [5];
        logic [3:0] qs  [5];
        logic       tcs [5];
        ens = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b1};
        qs  = '{4'hF, 4'hF, 4'h0, 4'h1, 4'h1};
        tcs = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
        bus.stop = 1'b1; bus.en = 1'b0;
        tick();
        bus.stop = 1'b0;
        bus.d = 4'hE; bus.limit = 4'h1; bus.auto_reload = 1'b0; bus.load = 1'b1;
        tick();
        bus.load = 1'b0; bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        for (int unsigned i = 0; i < 5; i++) begin
            bus.en = ens[i];
            tick();
            checks++;
            if (bus.q !== qs[i] || bus.tc !== tcs[i]) begin
                errors++;
                $display("FAIL wrap_gating step %0d: got q=%0h tc=%0b expected q=%0h tc=%0b",
                         i, bus.q, bus.tc, qs[i], tcs[i]);
            end
        end
        checks++;
        if (bus.done !== 1'b1) begin
            errors++;
            $display("FAIL wrap_done: got done=%0b expected 1", bus.done);
        end
    endtask

    task automatic test_priority();
        // from DONE: start reloads rld (E)
        bus.en = 1'b0; bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        checks++;
        if (bus.q !== 4'hE || bus.busy !== 1'b1) begin
            errors++;
            $display("FAIL prio_restart: got q=%0h busy=%0b expected q=e busy=1", bus.q, bus.busy);
        end
        bus.d = 4'h7; bus.load = 1'b1; bus.stop = 1'b1; bus.en = 1'b1;
        tick();
        bus.load = 1'b0;
        checks++;
        if (bus.q !== 4'h7 || bus.busy !== 1'b1 || bus.tc !== 1'b0) begin
            errors++;
            $display("FAIL prio_load_stop: got q=%0h busy=%0b tc=%0b expected q=7 busy=1 tc=0",
                     bus.q, bus.busy, bus.tc);
        end
        tick();
        bus.stop = 1'b0;
        checks++;
        if (bus.q !== 4'h7 || bus.busy !== 1'b0 || bus.done !== 1'b0) begin
            errors++;
            $display("FAIL prio_stop: got q=%0h busy=%0b done=%0b expected q=7 busy=0 done=0",
                     bus.q, bus.busy, bus.done);
        end
        rst = 1'b1; bus.d = 4'h9; bus.load = 1'b1;
        tick();
        rst = 1'b0; bus.load = 1'b0; bus.en = 1'b0;
        checks++;
        if (bus.q !== 4'h0) begin
            errors++;
            $display("FAIL prio_rst_load: got q=%0h expected 0", bus.q);
        end
    endtask

    task automatic test_random();
        for (int unsigned i = 0; i < 600; i++) begin
            rst             = ($urandom_range(0, 59) == 0);
            bus.load        = ($urandom_range(0, 9) == 0);
            bus.stop        = ($urandom_range(0, 19) == 0);
            bus.start       = ($urandom_range(0, 5) == 0);
            bus.en          = ($urandom_range(0, 3) != 0);
            bus.d           = 4'($urandom);
            if ($urandom_range(0, 9) == 0) bus.limit = 4'($urandom);
            if ($urandom_range(0, 19) == 0) bus.auto_reload = ~bus.auto_reload;
            tick();
            checks++;
            if (bus.q !== 4'(m_q) || bus.tc !== m_tc || bus.busy !== m_run || bus.done !== m_done) begin
                errors++;
                $display("FAIL random cycle %0d: got q=%0h tc=%0b busy=%0b done=%0b expected q=%0h tc=%0b busy=%0b done=%0b",
                         i, bus.q, bus.tc, bus.busy, bus.done, m_q, m_tc, m_run, m_done);
            end
        end
        rst = 1'b0; bus.load = 1'b0; bus.stop = 1'b0; bus.start = 1'b0; bus.en = 1'b0;
    endtask

    initial begin
        checks = 0; errors = 0;
        m_q = 0; m_rld = 0; m_tc = 1'b0; m_run = 1'b0; m_done = 1'b0;
        rst = 1'b0;
        bus.d = '0; bus.load = 1'b0; bus.start = 1'b0; bus.stop = 1'b0;
        bus.en = 1'b0; bus.auto_reload = 1'b0; bus.limit = '0;
        #2;
        test_reset();
        test_idle_load();
        test_one_shot();
        test_restart_done();
        test_auto_reload();
        test_wrap_gating();
        test_priority();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
